// File: rtl/hc_tile_packer_pkg.sv
// Shared definitions for the tile packer and the downstream reduction block:
// state encoding plus tile-count and index-width helpers.
package hc_tile_packer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t COLLECT   = 2'd0;
    localparam state_t LAUNCH    = 2'd1;
    localparam state_t WAIT_DONE = 2'd2;

    function automatic int total_tiles(input int b, input int h, input int p);
        return b * h * p;
    endfunction

    // One spare bit so the index can represent TOTAL_TILES itself.
    function automatic int idx_width(input int b, input int h, input int p);
        return $clog2(b * h * p) + 1;
    endfunction

endpackage

// File: rtl/hc_tile_packer.sv
// Collects B*H*P tiles into a flat buffer, pulses start to the reduction block
// and holds the buffer until acc_done. Optional proto_err via HC_TILE_PACKER_ERR_EN.
module hc_tile_packer
    import hc_tile_packer_pkg::*;
#(
    parameter int B  = 1,
    parameter int H  = 4,
    parameter int P  = 4,
    parameter int N  = 128,
    parameter int DW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tile_valid,
    input  logic [N*DW-1:0]         tile_data,
    output logic                    tile_ready,
    input  logic                    flush,
    input  logic                    acc_done,
    output logic [B*H*P*N*DW-1:0]   hC_flat,
    output logic                    start,
    output logic                    busy
`ifdef HC_TILE_PACKER_ERR_EN
    ,
    output logic                    proto_err
`endif
);

    localparam int TOTAL = total_tiles(B, H, P);
    localparam int IW    = idx_width(B, H, P);
    localparam int TW    = N * DW;
    localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

    state_t        state;
    logic [IW-1:0] tile_index;
    logic          accept;
    logic          last_tile;

    assign tile_ready = (state == COLLECT) && !flush;
    assign accept     = tile_valid && tile_ready;
    assign last_tile  = (tile_index == LAST_IDX);
    assign busy       = (state == LAUNCH) || (state == WAIT_DONE);

    // start is only ever set on the edge entering LAUNCH, so it lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            tile_index <= '0;
            start      <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                COLLECT: begin
                    if (flush) begin
                        tile_index <= '0;
                    end else if (accept) begin
                        if (last_tile) begin
                            tile_index <= '0;
                            state      <= LAUNCH;
                            start      <= 1'b1;
                        end else begin
                            tile_index <= tile_index + IW'(1);
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (acc_done) begin
                        state <= COLLECT;
                    end
                end
                default: begin
                    state      <= COLLECT;
                    tile_index <= '0;
                end
            endcase
        end
    end

    // Tile storage is deliberately not reset; a fresh run overwrites every slot.
    always_ff @(posedge clk) begin
        for (int s = 0; s < TOTAL; s++) begin
            if (accept && (tile_index == IW'(s))) begin
                hC_flat[s*TW +: TW] <= tile_data;
            end
        end
    end

`ifdef HC_TILE_PACKER_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if ((acc_done && (state != WAIT_DONE)) || (tile_valid && busy)) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hc_tile_packer.sv
// Scoreboard bench for hc_tile_packer: randomized tiles, a slot-array reference
// model and a monitor that checks every launch and the hold period.
module tb_hc_tile_packer;

    localparam int B     = 1;
    localparam int H     = 4;
    localparam int P     = 4;
    localparam int N     = 128;
    localparam int DW    = 16;
    localparam int TOTAL = B * H * P;
    localparam int TW    = N * DW;
    localparam int FW    = TOTAL * TW;
    localparam int N2    = 4;
    localparam int TW2   = N2 * DW;
    localparam int E_CHK = 5 * N + 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          tile_valid;
    logic [TW-1:0] tile_data;
    logic          flush;
    logic          acc_done;
    logic          tile_ready;
    logic [FW-1:0] hC_flat;
    logic          start;
    logic          busy;
`ifdef HC_TILE_PACKER_ERR_EN
    logic          proto_err;
    logic          proto_err2;
`endif

    logic           tile_valid2;
    logic [TW2-1:0] tile_data2;
    logic           flush2;
    logic           acc_done2;
    logic           tile_ready2;
    logic [TW2-1:0] hC_flat2;
    logic           start2;
    logic           busy2;

    hc_tile_packer #(.B(B), .H(H), .P(P), .N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tile_valid (tile_valid),
        .tile_data  (tile_data),
        .tile_ready (tile_ready),
        .flush      (flush),
        .acc_done   (acc_done),
        .hC_flat    (hC_flat),
        .start      (start),
        .busy       (busy)
`ifdef HC_TILE_PACKER_ERR_EN
        ,
        .proto_err  (proto_err)
`endif
    );

    hc_tile_packer #(.B(1), .H(1), .P(1), .N(N2), .DW(DW)) dut_single (
        .clk        (clk),
        .rst        (rst),
        .tile_valid (tile_valid2),
        .tile_data  (tile_data2),
        .tile_ready (tile_ready2),
        .flush      (flush2),
        .acc_done   (acc_done2),
        .hC_flat    (hC_flat2),
        .start      (start2),
        .busy       (busy2)
`ifdef HC_TILE_PACKER_ERR_EN
        ,
        .proto_err  (proto_err2)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: slot image, tiles gathered so far, and run phase.
    logic [FW-1:0]  m_img;
    int             m_count   = 0;
    bit             m_launch  = 1'b0;
    bit             m_waiting = 1'b0;
    bit             m_err     = 1'b0;
    logic [FW-1:0]  exp_q[$];
    logic [TW2-1:0] exp_q2[$];

    task automatic checkOutput(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkImage(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            for (int e = 0; e < TOTAL * N; e++) begin
                if (act[e*DW +: DW] !== req[e*DW +: DW]) begin
                    $display("[TB] FAIL %s: element %0d got %h required %h at %0t",
                             name, e, act[e*DW +: DW], req[e*DW +: DW], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [TW-1:0] patternTile(input int t);
        logic [TW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = {8'(t), 8'(i)};
        return d;
    endfunction

    function automatic logic [TW-1:0] randTile();
        logic [TW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    task automatic resetModel();
        m_count   = 0;
        m_launch  = 1'b0;
        m_waiting = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic modelEdge(input logic v, input logic [TW-1:0] d, input logic fl, input logic ad);
        if ((ad && !m_waiting) || (v && (m_launch || m_waiting))) m_err = 1'b1;
        if (m_launch) begin
            m_launch  = 1'b0;
            m_waiting = 1'b1;
        end else if (m_waiting) begin
            if (ad) m_waiting = 1'b0;
        end else if (fl) begin
            m_count = 0;
        end else if (v) begin
            m_img[m_count*TW +: TW] = d;
            m_count++;
            if (m_count == TOTAL) begin
                exp_q.push_back(m_img);
                m_count  = 0;
                m_launch = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [TW-1:0] d, input logic fl, input logic ad);
        @(negedge clk);
        tile_valid = v;
        tile_data  = d;
        flush      = fl;
        acc_done   = ad;
        @(posedge clk);
        modelEdge(v, d, fl, ad);
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        rst        = 1'b0;
        tile_valid = 1'b0;
        flush      = 1'b0;
        acc_done   = 1'b0;
        resetModel();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor for the 16-tile instance: per-cycle handshake plus launch/hold data.
    initial begin : monitor
        logic [FW-1:0] held;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            checkOutput("tile_ready", tile_ready, !(m_launch || m_waiting) && !flush);
            checkOutput("start", start, m_launch);
            checkOutput("busy", busy, m_launch || m_waiting);
`ifdef HC_TILE_PACKER_ERR_EN
            checkOutput("proto_err", proto_err, m_err);
`endif
            if (start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_start: start=1 required no launch at %0t", $time);
                end else begin
                    held = exp_q.pop_front();
                    checkImage("hC_flat_launch", hC_flat, held);
                end
            end else if (m_waiting) begin
                checkImage("hC_flat_hold", hC_flat, held);
            end
        end
    end

    initial begin : monitor_single
        forever begin
            @(negedge clk);
            #1;
            if (start2 === 1'b1) begin
                if (exp_q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_start_single: start=1 required no launch at %0t", $time);
                end else begin
                    checkImage("hC_flat_single", FW'(hC_flat2), FW'(exp_q2.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded bound", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int guard;
        rst         = 1'b0;
        tile_valid  = 1'b0;
        tile_data   = '0;
        flush       = 1'b0;
        acc_done    = 1'b0;
        tile_valid2 = 1'b0;
        tile_data2  = '0;
        flush2      = 1'b0;
        acc_done2   = 1'b0;
        m_img       = '0;
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] pattern tiles, valid every cycle");
        for (int t = 0; t < TOTAL; t++) applyStimulus(1'b1, patternTile(t), 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        #1;
        checkCount("elem_5_7", int'(hC_flat[E_CHK*DW +: DW]), 16'h0507);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        $display("[TB] random gaps, long acc_done hold-off");
        guard = 0;
        while (!m_launch && guard < 400) begin
            applyStimulus(1'($urandom_range(0, 1)), randTile(), 1'b0, 1'b0);
            guard++;
        end
        checkOutput("random_fill_launched", m_launch, 1'b1);
        repeat (50) applyStimulus(1'($urandom_range(0, 1)), randTile(), 1'($urandom_range(0, 1)), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        $display("[TB] flush after 7 tiles");
        for (int t = 0; t < 7; t++) applyStimulus(1'b1, randTile(), 1'b0, 1'b0);
        applyStimulus(1'b1, randTile(), 1'b1, 1'b0);
        for (int t = 0; t < TOTAL; t++) applyStimulus(1'b1, randTile(), 1'b0, 1'b0);
        idle(3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        $display("[TB] acc_done while collecting");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        idle(3);

        $display("[TB] reset during WAIT_DONE and mid-collection");
        for (int t = 0; t < TOTAL; t++) applyStimulus(1'b1, randTile(), 1'b0, 1'b0);
        idle(3);
        applyReset(2);
        for (int t = 0; t < 5; t++) applyStimulus(1'b1, randTile(), 1'b0, 1'b0);
        applyReset(1);
        for (int t = 0; t < TOTAL; t++) applyStimulus(1'b1, randTile(), 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        $display("[TB] single-tile configuration");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checkOutput("single_ready_idle", tile_ready2, 1'b1);
            tile_valid2 = 1'b1;
            tile_data2  = {$urandom, $urandom};
            exp_q2.push_back(tile_data2);
            @(negedge clk);
            tile_valid2 = 1'b0;
            #1;
            checkOutput("single_start", start2, 1'b1);
            checkOutput("single_busy_launch", busy2, 1'b1);
            checkOutput("single_ready_busy", tile_ready2, 1'b0);
            @(negedge clk);
            #1;
            checkOutput("single_start_clear", start2, 1'b0);
            checkOutput("single_busy_wait", busy2, 1'b1);
            repeat (k) begin
                @(negedge clk);
                #1;
                checkOutput("single_busy_hold", busy2, 1'b1);
            end
            @(negedge clk);
            acc_done2 = 1'b1;
            @(negedge clk);
            acc_done2 = 1'b0;
            #1;
            checkOutput("single_busy_done", busy2, 1'b0);
        end

        idle(3);
        checkCount("pending_launches", exp_q.size(), 0);
        checkCount("pending_launches_single", exp_q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc_tile_packer.md
HC_TILE_PACKER -- requirements
Module: hc_tile_packer

Interface
REQ-001 Parameter B, default 1, batch count.
REQ-002 Parameter H, default 4, head count.
REQ-003 Parameter P, default 4, head-dim count.
REQ-004 Parameter N, default 128, elements per tile (state dim).
REQ-005 Parameter DW, default 16, element width (FP16 bit pattern, opaque to this block).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 tile_valid  input  1  upstream tile present on tile_data.
REQ-009 tile_data  input  N*DW  one tile; element i at bits [(i+1)*DW-1 -: DW].
REQ-010 tile_ready  output  1  packer accepts a tile this cycle.
REQ-011 flush  input  1  abort current collection.
REQ-012 acc_done  input  1  one-cycle completion pulse from the downstream reduction block.
REQ-013 hC_flat  output  B*H*P*N*DW  packed tiles to the reduction block.
REQ-014 start  output  1  one-cycle launch pulse to the reduction block.
REQ-015 busy  output  1  high in LAUNCH and WAIT_DONE.

Function
REQ-016 TOTAL_TILES = B*H*P; tile index register width $clog2(TOTAL_TILES)+1.
REQ-017 States: COLLECT, LAUNCH, WAIT_DONE; no other reachable state.
REQ-018 tile_ready SHALL be 1 exactly when state == COLLECT and flush == 0 (combinational).
REQ-019 Handshake: accept = tile_valid && tile_ready; tile_data written to slot tile_index, i.e. hC_flat element (tile_index*N+i), tile_index incremented, same edge.
REQ-020 tile_valid without tile_ready SHALL be ignored; data not captured, index unchanged.
REQ-021 Accept with tile_index == TOTAL_TILES-1 SHALL move COLLECT -> LAUNCH; tile_index wraps to 0.
REQ-022 LAUNCH lasts exactly one cycle with start = 1, then -> WAIT_DONE; start registered, never high in other states.
REQ-023 Latency: start high the cycle immediately after the last tile's accepting edge.
REQ-024 WAIT_DONE: hC_flat SHALL hold stable until acc_done == 1; then -> COLLECT next edge.
REQ-025 acc_done in COLLECT or LAUNCH SHALL be ignored.
REQ-026 flush in COLLECT: tile_index <- 0, any simultaneous tile dropped, stored data not cleared; flush in LAUNCH/WAIT_DONE ignored.
REQ-027 TOTAL_TILES == 1: every accepted tile triggers LAUNCH.

Reset
REQ-028 rst low SHALL asynchronously force state = COLLECT, tile_index = 0, start = 0, busy = 0; hC_flat contents unspecified (no reset on data storage).
REQ-029 Reset mid-collection or mid-WAIT_DONE SHALL discard the run; no start issued for partial data.

Configuration
REQ-030 Macro HC_TILE_PACKER_ERR_EN: when defined, add output proto_err (1 bit), sticky, set on acc_done outside WAIT_DONE or tile_valid in LAUNCH/WAIT_DONE, cleared only by reset.
REQ-031 Without HC_TILE_PACKER_ERR_EN: port proto_err absent, no related logic; all other behaviour identical.

Structure
REQ-032 Shared package holds state encoding (COLLECT=0, LAUNCH=1, WAIT_DONE=2) and TOTAL_TILES/index-width helper functions, shared with the reduction block.
REQ-033 Single module, no sub-modules; slot write decoder inline.

Verification
REQ-034 Defaults, 16 tiles with tile t element i = {t[7:0], i[7:0]}, valid every cycle -> 16 accepts, start 1 cycle after 16th, hC_flat element (t*128+i) matches.
REQ-035 Random tile_valid gaps, acc_done held off 50 cycles -> tile_ready low, hC_flat unchanged for all 50 cycles, returns to COLLECT the cycle after acc_done.
REQ-036 flush after 7 tiles with tile_valid=1 same cycle -> that tile dropped, next 16 tiles land in slots 0..15, single start.
REQ-037 rst low during WAIT_DONE then 16 fresh tiles -> no start before 16th accept; state COLLECT after reset.
REQ-038 With HC_TILE_PACKER_ERR_EN: acc_done pulse in COLLECT -> proto_err = 1 next edge, stays 1 until rst; without macro, same stimulus -> normal operation.
REQ-039 B=H=P=1 -> start follows every accepted tile, busy for 2+ cycles each.
